// File: rtl/frame_delay_timer_pkg.sv
// ISO/IEC 14443A shared constants and types used by the PICC digital front end.
package ISO14443A_pkg;

  // Frame delay times in carrier clocks, selected by the last PCD data bit.
  localparam int unsigned FDT_LAST_BIT_0 = 1172;
  localparam int unsigned FDT_LAST_BIT_1 = 1236;

  // Frame delay counter width; 1236 fits below 2048.
  localparam int unsigned FDT_CNT_W = 11;

  typedef logic [FDT_CNT_W-1:0] fdt_cnt_t;

  typedef enum logic [0:0] {
    FDT_IDLE     = 1'b0,
    FDT_COUNTING = 1'b1
  } fdt_state_t;

  // Compensated frame delay target for a given last bit and fixed latency.
  function automatic fdt_cnt_t fdt_target(input logic last_bit, input int unsigned adjust);
    int unsigned nominal;
    nominal = last_bit ? FDT_LAST_BIT_1 : FDT_LAST_BIT_0;
    return FDT_CNT_W'(nominal - adjust);
  endfunction

endpackage

// File: rtl/frame_delay_timer_if.sv
// Connection between the pause_n synchroniser / rx decoder and the tx trigger.
interface frame_delay_timer_if;

  logic pause_n_synchronised;
  logic last_rx_bit;
  logic trigger;

  // Upstream side: drives pause and last bit, observes trigger.
  modport master (
    output pause_n_synchronised,
    output last_rx_bit,
    input  trigger
  );

  // Timer side.
  modport slave (
    input  pause_n_synchronised,
    input  last_rx_bit,
    output trigger
  );

endinterface

// File: rtl/frame_delay_timer_rise_detect.sv
// Rising-edge detector for an already synchronised level; reusable by rx.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise_c
);

  logic r_prev;

  // Previous sample; resets high so a level held high out of reset is not a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise_c = i_sig & ~r_prev;

endmodule

// File: rtl/frame_delay_timer.sv
// Frame delay timer: counts carrier clocks from end-of-pause and pulses trigger
// so the tx modulation edge lands on the ISO/IEC 14443-3 frame delay time.
module frame_delay_timer
  import ISO14443A_pkg::*;
#(
  parameter int unsigned TIMING_ADJUST = 0
) (
  input  logic                clk,
  input  logic                rst,
  frame_delay_timer_if.slave  fdt_if
);

  // Compensation larger than the shorter FDT would make the target meaningless.
  if (TIMING_ADJUST >= FDT_LAST_BIT_0) begin : g_bad_adjust
    $error("frame_delay_timer: TIMING_ADJUST must be below FDT_LAST_BIT_0");
  end

  localparam fdt_cnt_t CNT_ONE = FDT_CNT_W'(1);
  localparam fdt_cnt_t CNT_MAX = {FDT_CNT_W{1'b1}};

  fdt_state_t r_state;
  fdt_state_t w_state_next;
  fdt_cnt_t   r_count;
  fdt_cnt_t   w_count_next;
  fdt_cnt_t   w_target;
  logic       r_trigger;
  logic       w_trigger_next;
  logic       w_rise;
  logic       w_pause;
  logic       w_reached;

  rise_detect u_rise_detect (
    .clk      (clk),
    .rst      (rst),
    .i_sig    (fdt_if.pause_n_synchronised),
    .o_rise_c (w_rise)
  );

  // Target follows last_rx_bit live: rx resolves the bit only after EOC.
  assign w_target  = fdt_target(fdt_if.last_rx_bit, TIMING_ADJUST);
  assign w_pause   = ~fdt_if.pause_n_synchronised;
  assign w_reached = (r_count >= w_target);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FDT_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a rise restarts, a pause aborts, reaching the target finishes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FDT_IDLE: begin
        if (w_rise) begin
          w_state_next = FDT_COUNTING;
        end
      end
      FDT_COUNTING: begin
        if (w_rise) begin
          w_state_next = FDT_COUNTING;
        end else if (w_pause) begin
          w_state_next = FDT_IDLE;
        end else if (w_reached) begin
          w_state_next = FDT_IDLE;
        end
      end
      default: w_state_next = FDT_IDLE;
    endcase
  end

  // Counter and trigger next values; same priority as the state transitions.
  always_comb begin
    w_count_next   = r_count;
    w_trigger_next = 1'b0;
    case (r_state)
      FDT_IDLE: begin
        if (w_rise) begin
          w_count_next = CNT_ONE;
        end
      end
      FDT_COUNTING: begin
        if (w_rise) begin
          w_count_next = CNT_ONE;
        end else if (w_pause) begin
          w_count_next = r_count;
        end else if (w_reached) begin
          w_trigger_next = 1'b1;
        end else if (r_count != CNT_MAX) begin
          w_count_next = r_count + CNT_ONE;
        end
      end
      default: begin
        w_count_next   = '0;
        w_trigger_next = 1'b0;
      end
    endcase
  end

  // Counter and trigger registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_trigger <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_trigger <= w_trigger_next;
    end
  end

  assign fdt_if.trigger = r_trigger;

endmodule

// File: tb/tb_frame_delay_timer.sv
// Self-checking bench for frame_delay_timer with TIMING_ADJUST = 5.
module tb_frame_delay_timer;

  localparam int ADJ    = 5;
  localparam int LAT_B1 = 1236 - ADJ;
  localparam int LAT_B0 = 1172 - ADJ;

  logic clk = 1'b0;
  logic rst;

  frame_delay_timer_if intf ();

  frame_delay_timer #(.TIMING_ADJUST(ADJ)) dut (
    .clk    (clk),
    .rst    (rst),
    .fdt_if (intf)
  );

  always #5 clk = ~clk;

  int cyc        = 0;
  int n_checks   = 0;
  int n_fail     = 0;
  int trig_count = 0;
  int last_trig  = -1;
  int exp_q[$];

  function automatic int fdt_of(input logic lb);
    return lb ? LAT_B1 : LAT_B0;
  endfunction

  // Reference model: an end-of-pause at edge e0 earns a trigger at the first later
  // edge whose elapsed time reaches the FDT of the bit seen then, unless a pause,
  // a newer end-of-pause or a reset comes first.
  initial begin : model
    int   e0;
    logic pp;
    e0 = -1;
    pp = 1'b1;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        e0 = -1;
        pp = 1'b1;
      end else begin
        if (intf.pause_n_synchronised && !pp) begin
          e0 = cyc;
        end else if (!intf.pause_n_synchronised) begin
          e0 = -1;
        end else if (e0 >= 0 && (cyc - e0) >= fdt_of(intf.last_rx_bit)) begin
          exp_q.push_back(cyc);
          e0 = -1;
        end
        pp = intf.pause_n_synchronised;
      end
    end
  end

  // Monitor: every observed trigger must match the next expected edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL missed_trigger expected_edge=%0d now=%0d", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (intf.trigger !== 1'b0) begin
        trig_count = trig_count + 1;
        last_trig  = cyc;
        n_checks   = n_checks + 1;
        if (intf.trigger === 1'b1 && exp_q.size() > 0 && exp_q[0] == cyc) begin
          void'(exp_q.pop_front());
        end else begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_trigger edge=%0d value=%b expected_edge=%0d",
                   cyc, intf.trigger, (exp_q.size() > 0) ? exp_q[0] : -1);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL timeout edge=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Hold pause low for len cycles, release, and return the edge number of E0.
  task automatic release_pause(input int len, output int e0);
    intf.pause_n_synchronised = 1'b0;
    repeat (len) @(negedge clk);
    intf.pause_n_synchronised = 1'b1;
    e0 = cyc + 1;
  endtask

  // Directed check against constants from the plan: trigger count and latency.
  task automatic check_window(input string name, input int base, input int exp_n,
                              input int e0, input int exp_lat);
    n_checks = n_checks + 1;
    if (trig_count - base != exp_n) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_count got=%0d want=%0d", name, trig_count - base, exp_n);
    end
    if (exp_n > 0) begin
      n_checks = n_checks + 1;
      if (last_trig - e0 != exp_lat) begin
        n_fail = n_fail + 1;
        $display("FAIL %s_latency got=%0d want=%0d", name, last_trig - e0, exp_lat);
      end
    end
  endtask

  initial begin : stimulus
    int e0;
    int e0b;
    int base;
    int gap;

    rst                       = 1'b1;
    intf.pause_n_synchronised = 1'b1;
    intf.last_rx_bit          = 1'b0;
    repeat (3) @(negedge clk);
    n_checks = n_checks + 1;
    if (intf.trigger !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_trigger got=%b want=0", intf.trigger);
    end
    rst = 1'b0;

    // High out of reset is not a rise.
    base = trig_count;
    repeat (1400) @(negedge clk);
    check_window("post_reset_high", base, 0, 0, 0);

    // Single pause, last bit 1 then 0.
    intf.last_rx_bit = 1'b1;
    base = trig_count;
    release_pause(8, e0);
    repeat (1300) @(negedge clk);
    check_window("lb1", base, 1, e0, LAT_B1);

    intf.last_rx_bit = 1'b0;
    base = trig_count;
    release_pause(8, e0);
    repeat (1300) @(negedge clk);
    check_window("lb0", base, 1, e0, LAT_B0);

    // New pause at count 600 restarts the frame delay.
    intf.last_rx_bit = 1'b1;
    base = trig_count;
    release_pause(8, e0);
    repeat (600) @(negedge clk);
    release_pause(5, e0);
    repeat (1300) @(negedge clk);
    check_window("restart600", base, 1, e0, LAT_B1);

    // Last bit 1->0 once count is 1200: target already passed, fire next edge.
    intf.last_rx_bit = 1'b1;
    base = trig_count;
    release_pause(8, e0);
    repeat (1200) @(negedge clk);
    intf.last_rx_bit = 1'b0;
    repeat (200) @(negedge clk);
    check_window("lb_1to0", base, 1, e0, 1200);

    // Last bit 0->1 at count 1100: the longer target applies.
    intf.last_rx_bit = 1'b0;
    base = trig_count;
    release_pause(8, e0);
    repeat (1100) @(negedge clk);
    intf.last_rx_bit = 1'b1;
    repeat (300) @(negedge clk);
    check_window("lb_0to1", base, 1, e0, LAT_B1);

    // Reset at count 1000 with input held high: nothing survives.
    base = trig_count;
    release_pause(8, e0);
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks = n_checks + 1;
    if (intf.trigger !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL midreset_trigger got=%b want=0", intf.trigger);
    end
    rst = 1'b0;
    repeat (1400) @(negedge clk);
    check_window("midreset", base, 0, e0, 0);

    // Frame of 20 pauses, 128 clocks apart: one trigger after the last rise.
    base = trig_count;
    for (int i = 0; i < 20; i++) begin
      release_pause(4, e0);
      repeat (124) @(negedge clk);
    end
    repeat (1200) @(negedge clk);
    check_window("frame20", base, 1, e0, LAT_B1);

    // Pause sampled on the very edge the target is reached: abort wins.
    base = trig_count;
    release_pause(8, e0);
    repeat (LAT_B1) @(negedge clk);
    release_pause(6, e0b);
    repeat (1300) @(negedge clk);
    check_window("abort_at_target", base, 1, e0b, LAT_B1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      intf.last_rx_bit = 1'($urandom_range(0, 1));
      release_pause(int'($urandom_range(1, 6)), e0);
      gap = int'($urandom_range(1, 1400));
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 199) == 0) intf.last_rx_bit = ~intf.last_rx_bit;
        rst = ($urandom_range(0, 1999) == 0);
      end
      rst = 1'b0;
    end

    repeat (1400) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL missing_at_end expected_edge=%0d", exp_q[0]);
      void'(exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_delay_timer.md
# frame_delay_timer

Frame delay timer for the ISO/IEC 14443A PICC digital front end. After each end-of-pause (rising edge of the synchronised pause_n), it counts carrier clocks. It then pulses `trigger` so that the Tx load-modulation edge lands exactly at the ISO/IEC 14443-3 §6.2.1.1 frame delay time (1172/fc if the last PCD bit was 0, 1236/fc if it was 1). It sits between the pause_n synchroniser and the rx decoder on one side and the tx encoder on the other.

## Interface
- `TIMING_ADJUST`, default 0: number of clocks to subtract from the nominal FDT to compensate for fixed latency. This latency is the pause_n synchroniser/AFE delay plus the trigger-to-modulation delay in tx (2 clocks). Legal range is 0..1171.
- `clk`  in  1  13.56 MHz carrier clock; the block has one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `pause_n_synchronised`  in  1  PCD pause indicator, already synchronised to `clk`; 0 = pause in progress.
- `last_rx_bit`  in  1  value of the last data bit decoded by rx; it is valid by EOC, well before count 1100.
- `trigger`  out  1  single-cycle pulse meaning "start Tx modulation now".

## Operation
- Rise detection:
  - A register `prev` holds the previous sample of `pause_n_synchronised`.
  - A rise is `pause_n_synchronised & ~prev`.
- Target: `target = (last_rx_bit ? 1236 : 1172) - TIMING_ADJUST`.
  - The target is evaluated every cycle from the current `last_rx_bit`.
  - It is not latched at the pause rise, because rx resolves the last bit only after EOC.
- States:
  - **IDLE**: counter holds, `trigger` = 0.
    - On a rise: go to COUNTING with count = 1.
  - **COUNTING**: count increments by 1 per clock.
    - When `count >= target`: assert `trigger` for exactly one cycle and go to IDLE.
    - If `pause_n_synchronised` = 0 (a new pause): abort to IDLE with no trigger.
    - On a rise while counting (a new end-of-pause): restart with count = 1.
- The comparison is `>=`, not `==`. If `last_rx_bit` changes from 1 to 0 after count has already passed the 0-target, the trigger fires on the next cycle.
- Counter width is 11 bits unsigned (max 1236 < 2048). The counter saturates and never wraps; a wrap is unreachable because `trigger` fires first.
- Intermediate pauses inside a PCD frame restart the count, so only the final pause of a frame produces a trigger.
- tx ignores `trigger` when it has nothing to send; this block does not qualify it.

## Timing
- Reset values: `trigger` = 0, state = IDLE, count = 0, `prev` = 1.
  - Because `prev` resets to 1, `pause_n_synchronised` held high out of reset is not a rise.
- Define E0 as the first rising clk edge that samples `pause_n_synchronised` = 1 after an edge that sampled 0.
- `trigger` goes high at edge E0 + target and low at E0 + target + 1. Total latency from E0 is exactly `target` clocks.
- With `TIMING_ADJUST` = 5 and an ideal upstream, the PCD-side pause rise to the first tx modulation edge falls in [1172, 1172+1) or [1236, 1236+1) carrier periods.
  - This must be within 80 ns of the ideal FDT.
- `rst` asserted mid-count: the next cycle is IDLE with `trigger` = 0, and no pending trigger survives.
- A rise in the same cycle as `count >= target`: the restart wins and no trigger is emitted.
- A pause fall in the same cycle as `count >= target`: the abort wins and no trigger is emitted.

## Structure
- Shared package `ISO14443A_pkg`:
  - `FDT_LAST_BIT_0` = 1172.
  - `FDT_LAST_BIT_1` = 1236.
  - The counter width localparam (11).
- One natural sub-module: `rise_detect`.
  - Contents: the `prev` register and the rise output.
  - Reset value: `prev` = 1.
  - It is reusable by rx.
- Top level: an elaboration-time check that `TIMING_ADJUST` < 1172.

## Test plan
All scenarios use `TIMING_ADJUST` = 5.
- `last_rx_bit` = 1, single pause released at E0 -> `trigger` high for exactly one cycle, at E0+1231.
- `last_rx_bit` = 0 -> `trigger` at E0+1167, one cycle.
- New pause (`pause_n_synchronised` = 0) at count 600, released again -> no trigger from the first rise; `trigger` at 1231 after the second rise.
- `last_rx_bit` 1→0 at count 1200 -> `trigger` on the next cycle (count 1201); 0→1 at count 1100 -> trigger at 1231.
- `rst` pulsed at count 1000 with input held high -> no `trigger` ever, because the post-reset high is not a rise.
- Frame of 20 pauses spaced 128 clocks apart -> exactly one `trigger`, at target clocks after the last rise.
